// File: rtl/branch_predict_unit.sv
// Branch resolution unit with an integrated bimodal BHT of saturating counters.
// Define BRANCH_PREDICT_PERF_CNT_EN to add saturating branch/mispredict performance counters.
module branch_predict_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int BHT_DEPTH  = 64,
    parameter int CTR_WIDTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] pred_pc_i,
    output logic                  pred_taken_o,
    input  logic                  valid_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  branch_i,
    input  logic [2:0]            branch_op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  pred_taken_i,
    output logic                  valid_o,
    output logic                  take_o,
    output logic                  mispredict_o
`ifdef BRANCH_PREDICT_PERF_CNT_EN
    ,
    output logic [31:0]           branch_cnt_o,
    output logic [31:0]           mispredict_cnt_o
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [2:0] BRANCH_BEQ      = 3'b000;
    localparam logic [2:0] BRANCH_BNE      = 3'b001;
    localparam logic [2:0] BRANCH_JAL_JALR = 3'b010;
    localparam logic [2:0] BRANCH_BLT      = 3'b100;
    localparam logic [2:0] BRANCH_BGE      = 3'b101;
    localparam logic [2:0] BRANCH_BLTU     = 3'b110;
    localparam logic [2:0] BRANCH_BGEU     = 3'b111;

    // Weakly-not-taken: MSB clear, every lower bit set.
    localparam logic [CTR_WIDTH-1:0] CTR_RST = {CTR_WIDTH{1'b1}} >> 1;
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] CTR_ONE = {{(CTR_WIDTH-1){1'b0}}, 1'b1};

    logic [CTR_WIDTH-1:0] bht_q [BHT_DEPTH];
    logic [CTR_WIDTH-1:0] bht_d [BHT_DEPTH];

    logic valid_q, valid_d;
    logic take_q, take_d;
    logic mispredict_q, mispredict_d;

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] train_idx;
    logic             cond;
    logic             trainable;
    logic             outcome;
    logic             resolve;
    logic             mispredict_ev;

    assign pred_idx  = pred_pc_i[IDX_W+1:2];
    assign train_idx = pc_i[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc_i[DATA_WIDTH-1:IDX_W+2], pred_pc_i[1:0],
                              pc_i[DATA_WIDTH-1:IDX_W+2], pc_i[1:0]};

    // Reading bht_q gives the pre-update value when lookup and training collide.
    assign pred_taken_o = bht_q[pred_idx][CTR_WIDTH-1];

    always_comb begin
        cond      = 1'b0;
        trainable = 1'b1;
        case (branch_op_i)
            BRANCH_BEQ:      cond = (a_i == b_i);
            BRANCH_BNE:      cond = (a_i != b_i);
            BRANCH_BLT:      cond = ($signed(a_i) <  $signed(b_i));
            BRANCH_BGE:      cond = ($signed(a_i) >= $signed(b_i));
            BRANCH_BLTU:     cond = (a_i <  b_i);
            BRANCH_BGEU:     cond = (a_i >= b_i);
            BRANCH_JAL_JALR: begin
                cond      = 1'b1;
                trainable = 1'b0;
            end
            default: begin
                cond      = 1'b0;
                trainable = 1'b0;
            end
        endcase
    end

    assign outcome       = branch_i & cond;
    assign resolve       = valid_i & ~stall_i & ~flush_i;
    assign mispredict_ev = branch_i & (outcome ^ pred_taken_i);

    always_comb begin
        bht_d = bht_q;
        if (resolve && branch_i && trainable) begin
            if (outcome) begin
                if (bht_q[train_idx] != CTR_MAX) bht_d[train_idx] = bht_q[train_idx] + CTR_ONE;
            end else begin
                if (bht_q[train_idx] != '0) bht_d[train_idx] = bht_q[train_idx] - CTR_ONE;
            end
        end
    end

    // Flush clears the result even while stalled; a plain stall holds it.
    always_comb begin
        valid_d      = valid_q;
        take_d       = take_q;
        mispredict_d = mispredict_q;
        if (flush_i) begin
            valid_d      = 1'b0;
            take_d       = 1'b0;
            mispredict_d = 1'b0;
        end else if (!stall_i) begin
            valid_d      = valid_i;
            take_d       = valid_i & outcome;
            mispredict_d = valid_i & mispredict_ev;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_RST;
            valid_q      <= 1'b0;
            take_q       <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            bht_q        <= bht_d;
            valid_q      <= valid_d;
            take_q       <= take_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign valid_o      = valid_q;
    assign take_o       = take_q;
    assign mispredict_o = mispredict_q;

`ifdef BRANCH_PREDICT_PERF_CNT_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (resolve && branch_i) begin
            if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_d = branch_cnt_q + 32'd1;
            if (mispredict_ev && (mispredict_cnt_q != 32'hFFFF_FFFF))
                mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_cnt_q     <= 32'd0;
            mispredict_cnt_q <= 32'd0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: stimulus queues expected {valid,take,mispredict},
// a monitor pops one entry per clock and compares; predictions are checked directly.
module tb_branch_predict_unit;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] JAL  = 3'b010;
    localparam logic [2:0] UNDF = 3'b011;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] pred_pc_i;
    logic        pred_taken_o;
    logic        valid_i, stall_i, flush_i, branch_i, pred_taken_i;
    logic [2:0]  branch_op_i;
    logic [31:0] a_i, b_i, pc_i;
    logic        valid_o, take_o, mispredict_o;
`ifdef BRANCH_PREDICT_PERF_CNT_EN
    logic [31:0] branch_cnt_o, mispredict_cnt_o;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int out_idx     = 0;
    logic [2:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    branch_predict_unit #(.DATA_WIDTH(32), .BHT_DEPTH(64), .CTR_WIDTH(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .pred_pc_i(pred_pc_i), .pred_taken_o(pred_taken_o),
        .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .branch_i(branch_i), .branch_op_i(branch_op_i),
        .a_i(a_i), .b_i(b_i), .pc_i(pc_i), .pred_taken_i(pred_taken_i),
        .valid_o(valid_o), .take_o(take_o), .mispredict_o(mispredict_o)
`ifdef BRANCH_PREDICT_PERF_CNT_EN
        , .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
        pred_pc_i = pc;
        #1;
        check(name, {31'b0, pred_taken_o}, {31'b0, exp});
    endtask

    // Called at a falling edge; applies one cycle of inputs and returns at the next falling edge.
    task automatic drive(input logic v, input logic st, input logic fl, input logic br,
                         input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic pt,
                         input logic ev, input logic et, input logic em);
        valid_i = v; stall_i = st; flush_i = fl; branch_i = br; branch_op_i = op;
        a_i = a; b_i = b; pc_i = pc; pred_taken_i = pt;
        exp_q.push_back({ev, et, em});
        @(negedge clk_i);
        valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; branch_i = 1'b0;
    endtask

    always @(posedge clk_i) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            check($sformatf("out_vtm[%0d]", out_idx),
                  {29'b0, valid_o, take_o, mispredict_o}, {29'b0, e});
            out_idx++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0; pred_pc_i = 32'h100;
        valid_i = 0; stall_i = 0; flush_i = 0; branch_i = 0; branch_op_i = BEQ;
        a_i = 0; b_i = 0; pc_i = 0; pred_taken_i = 0;
        #2;
        check("rst_outputs", {29'b0, valid_o, take_o, mispredict_o}, 32'd0);
        check_pred("rst_pred_100", 32'h100, 1'b0);
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Signed vs unsigned compare (entry 0: 01 -> 10 -> 01)
        drive(1,0,0,1, BLT,  32'hFFFF_FFFF, 32'd1, 32'h200, 0, 1,1,1);
        drive(1,0,0,1, BLTU, 32'hFFFF_FFFF, 32'd1, 32'h200, 0, 1,0,0);

        // Training and saturation at 0x40 (entry 16)
        check_pred("train_init", 32'h40, 1'b0);
        drive(1,0,0,1, BEQ, 7, 7, 32'h40, 0, 1,1,1);
        check_pred("train_t1", 32'h40, 1'b1);
        drive(1,0,0,1, BEQ, 7, 7, 32'h40, 1, 1,1,0);
        check_pred("train_t2", 32'h40, 1'b1);
        drive(1,0,0,1, BEQ, 7, 7, 32'h40, 1, 1,1,0);
        check_pred("train_t3_sat", 32'h40, 1'b1);
        drive(1,0,0,1, BEQ, 7, 8, 32'h40, 1, 1,0,1);
        check_pred("train_n1", 32'h40, 1'b1);
        drive(1,0,0,1, BEQ, 7, 8, 32'h40, 1, 1,0,1);
        check_pred("train_n2", 32'h40, 1'b0);
        drive(1,0,0,1, BEQ, 7, 8, 32'h40, 1, 1,0,1);
        drive(1,0,0,1, BEQ, 7, 8, 32'h40, 1, 1,0,1);
        check_pred("train_n4", 32'h40, 1'b0);
        drive(1,0,0,1, BEQ, 7, 7, 32'h40, 0, 1,1,1);
        check_pred("no_wrap", 32'h40, 1'b0);

        // Aliasing 0x140 with 0x40, read-before-write
        check_pred("alias_old", 32'h140, 1'b0);
        drive(1,0,0,1, BEQ, 3, 3, 32'h40, 0, 1,1,1);
        check_pred("alias_new", 32'h140, 1'b1);

        // Stall holds outputs and table (entry 0: 01 -> 10)
        drive(1,0,0,1, BEQ, 5, 5, 32'h300, 1, 1,1,0);
        for (int i = 0; i < 3; i++)
            drive(1,1,0,1, BNE, 5, 5, 32'h300, 1, 1,1,0);
        check_pred("stall_no_train", 32'h300, 1'b1);

        // Flush clears outputs and suppresses training
        drive(1,0,1,1, BEQ, 1, 2, 32'h40, 1, 0,0,0);
        check_pred("flush_no_train", 32'h40, 1'b1);
        drive(1,0,0,1, BGE,  32'd1, 32'hFFFF_FFFF, 32'h400, 1, 1,1,0);
        drive(1,0,0,1, BGEU, 32'd1, 32'hFFFF_FFFF, 32'h400, 0, 1,0,0);
        drive(1,0,0,1, BNE,  32'd1, 32'd2,         32'h400, 0, 1,1,1);
        drive(1,1,1,1, BEQ, 1, 2, 32'h40, 1, 0,0,0);
        check_pred("flush_stall_no_train", 32'h40, 1'b1);

        // JAL taken, not trained; non-branch; idle; undefined op (entry 32)
        drive(1,0,0,1, JAL, 0, 0, 32'h80, 0, 1,1,1);
        check_pred("jal_no_train", 32'h80, 1'b0);
        drive(1,0,0,0, BEQ, 4, 4, 32'h80, 1, 1,0,0);
        check_pred("nonbranch_no_train", 32'h80, 1'b0);
        drive(0,0,0,1, BEQ, 4, 4, 32'h80, 1, 0,0,0);
        drive(1,0,0,1, UNDF, 4, 4, 32'h80, 1, 1,0,1);
        drive(1,0,0,1, BEQ, 4, 4, 32'h80, 0, 1,1,1);
        check_pred("undef_no_train", 32'h80, 1'b1);

        // Asynchronous reset mid-operation
        drive(1,0,0,1, BEQ, 4, 4, 32'h40, 0, 1,1,1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_outputs", {29'b0, valid_o, take_o, mispredict_o}, 32'd0);
        check_pred("async_rst_pred", 32'h40, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

`ifdef BRANCH_PREDICT_PERF_CNT_EN
        drive(1,0,0,1, BEQ, 1, 1, 32'h500, 1, 1,1,0);
        drive(1,0,0,1, BEQ, 1, 1, 32'h504, 0, 1,1,1);
        drive(1,0,0,1, BNE, 1, 1, 32'h508, 0, 1,0,0);
        drive(1,0,0,0, BEQ, 1, 1, 32'h50C, 0, 1,0,0);
        drive(1,0,0,1, BLT, 1, 2, 32'h510, 0, 1,1,1);
        drive(1,0,0,1, JAL, 0, 0, 32'h514, 1, 1,1,0);
        check("branch_cnt", branch_cnt_o, 32'd5);
        check("mispredict_cnt", mispredict_cnt_o, 32'd2);
        force dut.branch_cnt_q = 32'hFFFF_FFFF;
        force dut.mispredict_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt_q;
        release dut.mispredict_cnt_q;
        drive(1,0,0,1, BEQ, 1, 1, 32'h518, 0, 1,1,1);
        check("branch_cnt_sat", branch_cnt_o, 32'hFFFF_FFFF);
        check("mispredict_cnt_sat", mispredict_cnt_o, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk_i);
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution unit with an integrated bimodal branch history table (BHT). Fetch gets a taken/not-taken prediction by PC, and execute resolves the branch condition, compares it against the prediction carried down the pipeline and trains the table. The block replaces the purely combinational branch comparator. It registers its result so the fetch redirect and the pipeline flush are driven from flops.

## Interface
- `DATA_WIDTH`, default 32: operand and PC width.
- `BHT_DEPTH`, default 64: number of BHT entries; must be a power of two, ≥ 2.
- `CTR_WIDTH`, default 2: width of each saturating counter, ≥ 1.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `pred_pc_i`  in  DATA_WIDTH  fetch PC to predict.
- `pred_taken_o`  out  1  combinational prediction for `pred_pc_i`.
- `valid_i`  in  1  execute-stage instruction valid.
- `stall_i`  in  1  execute stall; holds all state.
- `flush_i`  in  1  kills the registered result of the current cycle.
- `branch_i`  in  1  instruction is a branch or jump.
- `branch_op_i`  in  3  `pkg_config` `BRANCH_*` encoding.
- `a_i`, `b_i`  in  DATA_WIDTH  comparison operands.
- `pc_i`  in  DATA_WIDTH  PC of the resolving instruction.
- `pred_taken_i`  in  1  prediction made at fetch for this instruction.
- `valid_o`  out  1  registered result valid.
- `take_o`  out  1  registered actual outcome.
- `mispredict_o`  out  1  registered; the outcome differs from the prediction.
- `branch_cnt_o`, `mispredict_cnt_o`  out  32  performance counters; present only with the macro defined.

## Operation
- **Index:** IDX_W = log2(BHT_DEPTH); index = PC[IDX_W+1:2]. Bits [1:0] are ignored.
- **Prediction:** `pred_taken_o` = MSB of the BHT entry at the index of `pred_pc_i`.
- **Condition:**
  - BEQ/BNE use equality.
  - BLT/BGE use signed comparison.
  - BLTU/BGEU use unsigned comparison.
  - JAL_JALR is always taken.
  - Undefined ops evaluate as not taken.
  - If `branch_i`=0, the outcome is not taken.
- **Resolve event:** `valid_i`=1, `stall_i`=0 and `flush_i`=0.
- **Output register update:**
  - On a resolve event: `valid_o`←1, `take_o`←outcome, `mispredict_o`←`branch_i` & (outcome ≠ `pred_taken_i`).
  - If not stalled and no resolve event: all three outputs ←0.
  - If stalled: all three outputs hold.
- **Training:** a resolve event with `branch_i`=1 and op ≠ JAL_JALR updates the entry at the index of `pc_i`.
  - Taken: increment, saturating at all-ones.
  - Not taken: decrement, saturating at zero.
  - JAL_JALR and undefined ops never train the table.
- **Non-branches:** `branch_i`=0 with `pred_taken_i`=1 does not raise a mispredict. The fetch stage never predicts non-branches.

## Timing
- **Reset values:**
  - Every BHT entry resets to the weakly-not-taken value: MSB 0, all other bits 1 (01 for CTR_WIDTH=2; 0 for CTR_WIDTH=1).
  - `valid_o`, `take_o` and `mispredict_o` reset to 0.
  - Both counters reset to 0.
- **Latency:**
  - Prediction: 0 cycles, combinational.
  - Resolution: 1 cycle; inputs at edge N appear on the outputs after edge N.
- **Read-before-write:** if a lookup and a training update hit the same index in one cycle, `pred_taken_o` shows the pre-update value. The new value is visible from the next cycle.
- **Flush:** `flush_i` has priority over `valid_i`; the update is suppressed and the outputs clear.
  - `flush_i` with `stall_i` still clears the outputs: flush beats stall.
- **Reset mid-operation:** asserting `rst_ni` low clears the outputs and the table immediately, independent of the clock.

## Configuration
- **`BRANCH_PREDICT_PERF_CNT_EN` defined:**
  - `branch_cnt_o` increments on every resolve event with `branch_i`=1.
  - `mispredict_cnt_o` increments when the registered mispredict condition is set on that event.
  - Both saturate at 0xFFFF_FFFF.
- **`BRANCH_PREDICT_PERF_CNT_EN` undefined:** the counter ports and their logic are absent. Prediction and resolution behaviour is identical in both builds.

## Test plan
- **Reset prediction:** release reset, `pred_pc_i`=0x100 → `pred_taken_o`=0; outputs are 0 before the first edge.
- **Signed compare:** BLT with a=0xFFFF_FFFF, b=1, `pred_taken_i`=0 → next cycle `take_o`=1, `mispredict_o`=1, `valid_o`=1. Repeat with BLTU → `take_o`=0, `mispredict_o`=0.
- **Training and saturation:** resolve BEQ a=b at pc=0x40 three times. `pred_taken_o`@0x40 reads 0, then 1 after the first update, then stays 1. Then four not-taken resolves → reads 0; entry is 00, with no wrap to 11.
- **Aliasing and same-cycle update:** pc 0x40 and 0x140 with BHT_DEPTH=64 share an entry. A lookup of 0x140 in the same cycle as training at 0x40 returns the old value; the next cycle returns the new one.
- **Flush/stall:**
  - `stall_i`=1 holds `take_o`=1 across 3 cycles.
  - `flush_i`=1 with `valid_i`=1 → `valid_o`=0 and the entry is unchanged.
  - JAL_JALR → `take_o`=1 and the entry is untouched.
- **Perf counters (macro on):** 5 branches including 2 mispredicts → `branch_cnt_o`=5, `mispredict_cnt_o`=2. A forced count of 0xFFFF_FFFF holds on the next branch.
